tx_burst_sequencer: RTL and testbench

//  Per-burst controller between the symbol source and the GMSK modulator. On fire_burst it primes
//  the modulator with PRIME_SYMBOLS ones, streams burst_len payload symbols, then TAIL_SYMBOLS ones.
//  It gates modulator I/Q onto the RF chain with iq_valid, and generates the sample_strobe.

---
 rtl/tx_burst_pkg.sv | 14 +
 rtl/tx_sample_clkdiv.sv | 23 ++
 rtl/tx_burst_sequencer.sv | 109 ++++++++++
 tb/tb_tx_burst_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tx_burst_pkg.sv
// tx_burst_pkg: shared state encoding and default parameters for the burst sequencer
package tx_burst_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        PAYLOAD = 2'd2,
        TAIL    = 2'd3
    } state_t;
    localparam int DEF_IQ_WIDTH          = 8;
    localparam int DEF_CLOCKS_PER_SAMPLE = 4;
    localparam int DEF_PRIME_SYMBOLS     = 2;
    localparam int DEF_TAIL_SYMBOLS      = 3;
    localparam int DEF_LEN_WIDTH         = 8;
endpackage

// File: rtl/tx_sample_clkdiv.sv
// tx_sample_clkdiv: free-running divider, one-clock sample_strobe every CLOCKS_PER_SAMPLE clocks
module tx_sample_clkdiv
    import tx_burst_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE = DEF_CLOCKS_PER_SAMPLE
) (
    input  logic clock,
    input  logic reset_n,
    output logic sample_strobe
);
    localparam int CW = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_SAMPLE - 1);
    logic [CW-1:0] count;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count         <= '0;
            sample_strobe <= 1'b0;
        end else begin
            count         <= (count == LAST) ? '0 : count + CW'(1);
            sample_strobe <= count == LAST;
        end
    end
endmodule

// File: rtl/tx_burst_sequencer.sv
// tx_burst_sequencer: primes, streams and tails one GMSK burst and gates modulator I/Q onto the RF chain
module tx_burst_sequencer
    import tx_burst_pkg::*;
#(
    parameter int IQ_WIDTH          = DEF_IQ_WIDTH,
    parameter int CLOCKS_PER_SAMPLE = DEF_CLOCKS_PER_SAMPLE,
    parameter int PRIME_SYMBOLS     = DEF_PRIME_SYMBOLS,
    parameter int TAIL_SYMBOLS      = DEF_TAIL_SYMBOLS,
    parameter int LEN_WIDTH         = DEF_LEN_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       fire_burst,
    input  logic                       abort_burst,
    input  logic [LEN_WIDTH-1:0]       burst_len,
    input  logic                       sym_data,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    input  logic                       next_symbol_strobe,
    output logic                       current_symbol,
    output logic                       sample_strobe,
    output logic                       is_armed,
    input  logic signed [IQ_WIDTH-1:0] modulator_inphase,
    input  logic signed [IQ_WIDTH-1:0] modulator_quadrature,
    output logic signed [IQ_WIDTH-1:0] rfchain_inphase,
    output logic signed [IQ_WIDTH-1:0] rfchain_quadrature,
    output logic                       iq_valid,
    output logic                       burst_done,
    output logic                       underrun
);
    localparam logic [LEN_WIDTH-1:0] ONE        = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] PRIME_LAST = LEN_WIDTH'(PRIME_SYMBOLS - 1);
    localparam logic [LEN_WIDTH-1:0] TAIL_LAST  = LEN_WIDTH'(TAIL_SYMBOLS - 1);

    state_t               state, state_d;
    logic [LEN_WIDTH-1:0] cnt, cnt_d, len_q;
    logic                 strobe_q, sym_edge, last, cur_d, accept;

    tx_sample_clkdiv #(.CLOCKS_PER_SAMPLE(CLOCKS_PER_SAMPLE)) u_clkdiv (
        .clock        (clock),
        .reset_n      (reset_n),
        .sample_strobe(sample_strobe)
    );

    // A held modulator request must count as a single symbol
    assign sym_edge = next_symbol_strobe & ~strobe_q;
    assign accept   = (state == IDLE) & fire_burst;

    always_comb begin
        state_d = state;
        last    = 1'b0;
        case (state)
            IDLE: state_d = fire_burst ? PRIME : IDLE;
            PRIME: begin
                last    = sym_edge && cnt == PRIME_LAST;
                state_d = (abort_burst || (last && len_q == '0)) ? TAIL : last ? PAYLOAD : PRIME;
            end
            PAYLOAD: begin
                last    = sym_edge && cnt == len_q - ONE;
                state_d = (abort_burst || last) ? TAIL : PAYLOAD;
            end
            TAIL: begin
                last    = sym_edge && cnt == TAIL_LAST;
                state_d = last ? IDLE : TAIL;
            end
            default: state_d = IDLE;
        endcase
        cnt_d = (state_d != state || state == IDLE) ? '0 : sym_edge ? cnt + ONE : cnt;
        // The last payload symbol stays on air until the first tail edge replaces it
        cur_d = (state == PAYLOAD && sym_edge) ? (sym_valid ? sym_data : 1'b1)
              : (sym_edge || state == IDLE) ? 1'b1 : current_symbol;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            len_q    <= accept ? burst_len : len_q;
            strobe_q <= next_symbol_strobe;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            current_symbol     <= 1'b0;
            is_armed           <= 1'b0;
            sym_ready          <= 1'b0;
            burst_done         <= 1'b0;
            underrun           <= 1'b0;
            iq_valid           <= 1'b0;
            rfchain_inphase    <= '0;
            rfchain_quadrature <= '0;
        end else begin
            current_symbol     <= cur_d;
            is_armed           <= state_d == IDLE;
            sym_ready          <= state == PAYLOAD && sym_edge;
            burst_done         <= state == TAIL && last;
            underrun           <= accept ? 1'b0 : (state == PAYLOAD && sym_edge && !sym_valid) ? 1'b1 : underrun;
            iq_valid           <= state_d == PAYLOAD || state_d == TAIL;
            rfchain_inphase    <= iq_valid ? modulator_inphase : '0;
            rfchain_quadrature <= iq_valid ? modulator_quadrature : '0;
        end
    end
endmodule

// File: tb/tb_tx_burst_sequencer.sv
// tb_tx_burst_sequencer: directed self-checking bench for tx_burst_sequencer
module tb_tx_burst_sequencer;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       fire_burst, abort_burst, sym_data, sym_valid, next_symbol_strobe;
    logic [7:0] burst_len;
    logic       sym_ready, current_symbol, sample_strobe, is_armed, iq_valid, burst_done, underrun;
    logic [7:0] modulator_inphase, modulator_quadrature, rfchain_inphase, rfchain_quadrature;
    int         checks = 0;
    int         errors = 0;
    int         n_ready = 0;
    int         n_done = 0;
    int         n_iq = 0;

    tx_burst_sequencer dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fire_burst          (fire_burst),
        .abort_burst         (abort_burst),
        .burst_len           (burst_len),
        .sym_data            (sym_data),
        .sym_valid           (sym_valid),
        .sym_ready           (sym_ready),
        .next_symbol_strobe  (next_symbol_strobe),
        .current_symbol      (current_symbol),
        .sample_strobe       (sample_strobe),
        .is_armed            (is_armed),
        .modulator_inphase   (modulator_inphase),
        .modulator_quadrature(modulator_quadrature),
        .rfchain_inphase     (rfchain_inphase),
        .rfchain_quadrature  (rfchain_quadrature),
        .iq_valid            (iq_valid),
        .burst_done          (burst_done),
        .underrun            (underrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sym_ready) n_ready++;
        if (burst_done) n_done++;
        if (iq_valid) n_iq++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 16-clock symbol period, called and returning at a falling edge
    task automatic sym(input int hold, input logic d, input logic v, input logic exp, input string tag);
        sym_data = d;
        sym_valid = v;
        next_symbol_strobe = 1'b1;
        @(negedge clock);
        check(tag, current_symbol, exp);
        repeat (hold - 1) @(negedge clock);
        next_symbol_strobe = 1'b0;
        repeat (16 - hold) @(negedge clock);
    endtask

    task automatic fire(input logic [7:0] len, input string tag);
        burst_len = len;
        fire_burst = 1'b1;
        @(negedge clock);
        fire_burst = 1'b0;
        burst_len = 8'hA5;
        check(tag, is_armed, 1'b0);
    endtask

    task automatic run_burst(input int scen, input logic [7:0] len, input int hold, input int n,
                             input logic [15:0] exp, input logic [15:0] dat, input logic [15:0] vld,
                             input int exp_ready, input int exp_iq, input logic exp_underrun);
        int r0, d0, q0;
        r0 = n_ready;
        d0 = n_done;
        q0 = n_iq;
        fire(len, $sformatf("s%0d_fire_disarm", scen));
        check($sformatf("s%0d_underrun_clr", scen), underrun, 1'b0);
        for (int i = 0; i < n; i++)
            sym(hold, dat[i], vld[i], exp[i], $sformatf("s%0d_sym%0d", scen, i));
        repeat (2) @(negedge clock);
        check($sformatf("s%0d_ready_cnt", scen), n_ready - r0, exp_ready);
        check($sformatf("s%0d_done_cnt", scen), n_done - d0, 1);
        check($sformatf("s%0d_iq_cycles", scen), n_iq - q0, exp_iq);
        check($sformatf("s%0d_underrun", scen), underrun, exp_underrun);
        check($sformatf("s%0d_armed", scen), is_armed, 1'b1);
        check($sformatf("s%0d_rf_idle", scen), {rfchain_inphase, rfchain_quadrature}, 16'h0);
    endtask

    initial begin
        int d0;
        reset_n = 1'b0;
        fire_burst = 1'b0;
        abort_burst = 1'b0;
        burst_len = 8'd0;
        sym_data = 1'b0;
        sym_valid = 1'b0;
        next_symbol_strobe = 1'b0;
        modulator_inphase = 8'd37;
        modulator_quadrature = 8'hEC;
        repeat (2) @(negedge clock);
        check("rst_outputs", {current_symbol, sample_strobe, is_armed, iq_valid, sym_ready, burst_done, underrun}, 7'h0);
        check("rst_rf", {rfchain_inphase, rfchain_quadrature}, 16'h0);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            check($sformatf("s1_strobe_clk%0d", k), sample_strobe, (k % 4) == 0);
            check($sformatf("s1_armed_clk%0d", k), is_armed, 1'b1);
            check($sformatf("s1_iq_clk%0d", k), iq_valid, 1'b0);
        end
        check("s1_idle_sym", current_symbol, 1'b1);

        run_burst(2, 8'd5, 1, 10, 16'h03B7, 16'h0034, 16'hFFFF, 5, 128, 1'b0);
        run_burst(3, 8'd5, 6, 10, 16'h03B7, 16'h0034, 16'hFFFF, 5, 128, 1'b0);
        run_burst(4, 8'd4, 1, 9, 16'h01DB, 16'h0008, 16'hFFEF, 4, 112, 1'b1);

        d0 = n_done;
        fire(8'd10, "s5_fire_disarm");
        check("s5_underrun_clr", underrun, 1'b0);
        sym(1, 1'b0, 1'b1, 1'b1, "s5_prime0");
        fire(8'd7, "s5_midfire");
        sym(1, 1'b0, 1'b1, 1'b1, "s5_prime1");
        sym(1, 1'b1, 1'b1, 1'b1, "s5_pay0");
        sym(1, 1'b0, 1'b1, 1'b0, "s5_pay1");
        abort_burst = 1'b1;
        @(negedge clock);
        abort_burst = 1'b0;
        repeat (3) @(negedge clock);
        check("s5_hold_last", current_symbol, 1'b0);
        check("s5_iq_tail", iq_valid, 1'b1);
        check("s5_rf_i", rfchain_inphase, 8'd37);
        check("s5_rf_q", rfchain_quadrature, 8'hEC);
        check("s5_no_done_yet", n_done - d0, 0);
        sym(1, 1'b0, 1'b1, 1'b1, "s5_tail0");
        sym(1, 1'b0, 1'b1, 1'b1, "s5_tail1");
        check("s5_not_armed", is_armed, 1'b0);
        sym(1, 1'b0, 1'b1, 1'b1, "s5_tail2");
        check("s5_done_cnt", n_done - d0, 1);
        check("s5_armed", is_armed, 1'b1);
        repeat (20) @(negedge clock);
        check("s5_midfire_ignored", is_armed, 1'b1);

        run_burst(6, 8'd0, 1, 5, 16'h001F, 16'h0000, 16'hFFFF, 0, 48, 1'b0);

        d0 = n_done;
        fire(8'd5, "s6r_fire");
        sym(1, 1'b0, 1'b1, 1'b1, "s6r_prime0");
        sym(1, 1'b0, 1'b1, 1'b1, "s6r_prime1");
        sym(1, 1'b0, 1'b1, 1'b0, "s6r_pay0");
        check("s6r_iq_before", iq_valid, 1'b1);
        check("s6r_rf_before", rfchain_inphase, 8'd37);
        next_symbol_strobe = 1'b1;
        reset_n = 1'b0;
        #1;
        check("s6r_rst_outputs", {current_symbol, sample_strobe, is_armed, iq_valid, sym_ready, burst_done, underrun}, 7'h0);
        check("s6r_rst_rf", {rfchain_inphase, rfchain_quadrature}, 16'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        next_symbol_strobe = 1'b0;
        @(negedge clock);
        check("s6r_armed", is_armed, 1'b1);
        repeat (40) @(negedge clock);
        check("s6r_no_done", n_done - d0, 0);
        check("s6r_iq_idle", iq_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
